// File: rtl/bcd_serial_add_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and state type for the serial BCD adder controller.
// Optional feature macro used by the design: BCD_CHECK_EN (operand digit check).
// ----------------------------------------------------------------------------
package bcd_pkg;

    // Width of one packed BCD digit
    localparam int unsigned DIGIT_W = 4;

    // Largest legal BCD digit value
    localparam int unsigned BCD_MAX = 9;

    // Decimal adjust added when a digit sum exceeds BCD_MAX
    localparam int unsigned BCD_ADJ = 6;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// bcd_serial_add_ctrl_if
// Request/result bundle between operand/control logic (master) and the
// serial BCD add controller (slave).
//   start       : add request, honoured only while the controller is idle
//   a_bcd/b_bcd : packed BCD operands, digit i in bits [4i+3:4i]
//   busy        : digits are being processed
//   done        : one-cycle pulse, sum/cout/err valid
//   sum         : packed BCD result
//   cout        : decimal carry out of the top digit
//   err         : an operand digit >9 was seen (only with BCD_CHECK_EN)
// ----------------------------------------------------------------------------
interface bcd_serial_add_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    import bcd_pkg::*;

    localparam int unsigned W = DIGIT_W * DIGITS;

    logic         start;
    logic [W-1:0] a_bcd;
    logic [W-1:0] b_bcd;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    modport master (
        output start, a_bcd, b_bcd,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a_bcd, b_bcd,
        output busy, done, sum, cout, err
    );

endinterface : bcd_serial_add_ctrl_if

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// ----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder.
//   i_a, i_b  : operand digits (values above 9 are still added, no saturation)
//   i_cin     : decimal carry in
//   o_digit_c : (a + b + cin + (carry ? 6 : 0)) mod 16
//   o_cout_c  : decimal carry out, set when a + b + cin > 9
// ----------------------------------------------------------------------------
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_digit_c,
    output logic               o_cout_c
);

    localparam int unsigned SUM_W = DIGIT_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_adj;

    // Binary sum; 5 bits hold the worst case 15+15+1
    assign w_sum = SUM_W'(i_a) + SUM_W'(i_b) + SUM_W'(i_cin);

    assign o_cout_c = (w_sum > SUM_W'(BCD_MAX));

    // Decimal adjust, then keep the low digit only
    assign w_adj     = w_sum + (o_cout_c ? SUM_W'(BCD_ADJ) : SUM_W'(0));
    assign o_digit_c = DIGIT_W'(w_adj);

endmodule : bcd_digit_add

// File: rtl/bcd_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Steps a packed multi-digit BCD addition through one shared digit adder,
// least-significant digit first, one digit per clock, rippling the carry.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : bcd_serial_add_ctrl_if.slave (start, a_bcd, b_bcd in;
//         busy, done, sum, cout, err out; all outputs registered)
// Parameter:
//   DIGITS : digits per operand (>= 1)
// Build option:
//   BCD_CHECK_EN : when defined, err flags any operand digit >9 seen during
//                  the run; when undefined err is tied low.
// ----------------------------------------------------------------------------
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned LAST  = DIGITS - 1;

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN  = 2'(ST_RUN);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_busy;
    logic               r_done;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT_W-1:0] w_a_dig;
    logic [DIGIT_W-1:0] w_b_dig;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_dig_cout;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_idx == IDX_W'(LAST));

    // Current digit of each latched operand
    assign w_a_dig = r_a[r_idx * DIGIT_W +: DIGIT_W];
    assign w_b_dig = r_b[r_idx * DIGIT_W +: DIGIT_W];

    // Shared digit adder
    bcd_digit_add u_digit_add (
        .i_a       (w_a_dig),
        .i_b       (w_b_dig),
        .i_cin     (r_carry),
        .o_digit_c (w_digit),
        .o_cout_c  (w_dig_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, digit stepping and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a     <= bus.a_bcd;
                r_b     <= bus.b_bcd;
                r_idx   <= '0;
                r_carry <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_sum[r_idx * DIGIT_W +: DIGIT_W] <= w_digit;
                r_carry <= w_dig_cout;
                r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
                // Carry out of the top digit becomes cout
                if (w_last) begin
                    r_cout <= w_dig_cout;
                end
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic r_err;

    // Sticky invalid-digit flag, cleared by the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if ((r_state == S_RUN) &&
                     ((w_a_dig > DIGIT_W'(BCD_MAX)) || (w_b_dig > DIGIT_W'(BCD_MAX)))) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule : bcd_serial_add_ctrl

// File: tb/tb_bcd_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
// Scoreboard bench: the stimulus process pushes the expected result of every
// accepted add; a monitor pops and compares on each done pulse.
// ----------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          busy_cnt = 0;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: decimal digit-by-digit addition of the packed operands
    function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] s, output logic co,
                                    output logic e);
        int c;
        int da;
        int db;
        int t;
        c = 0;
        s = '0;
        e = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) e = 1'b1;
            t = da + db + c;
            if (t > 9) begin
                c = 1;
                t = (t + 6) % 16;
            end else begin
                c = 0;
            end
            s[4*i +: 4] = 4'(t);
        end
        co = (c != 0);
`ifndef BCD_CHECK_EN
        e = 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (allow_bad && ($urandom_range(0, 7) == 0))
                v[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d, sum %h)",
                                 cyc, bus.sum);
                    end else begin
                        e = sb_q.pop_front();
                        check("sum",        32'(bus.sum),  32'(e.sum));
                        check("cout",       32'(bus.cout), 32'(e.cout));
                        check("err",        32'(bus.err),  32'(e.err));
                        check("done_cycle", cyc,           e.cyc);
                        check("busy_cycles", 32'(busy_cnt), 32'(DIGITS));
                        check("busy_at_done", 32'(bus.busy), 32'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // One add request; returns DIGITS+1 negedges later so the next request
    // lands exactly at the minimum start-to-start spacing.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_bcd = a;
        bus.b_bcd = b;
        ref_add(a, b, e.sum, e.cout, e.err);
        e.cyc = cyc + 1 + DIGITS;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        // Operand changes after acceptance must not matter
        bus.a_bcd = W'($urandom);
        bus.b_bcd = W'($urandom);
        repeat (DIGITS) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        bus.start = 1'b0;
        bus.a_bcd = '0;
        bus.b_bcd = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum",  32'(bus.sum),  32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_err",  32'(bus.err),  32'd0);
        rst = 1'b0;

        // Directed adds, including full ripple and carry clearing
        issue(16'h1234, 16'h5678);
        issue(16'h9999, 16'h0001);
        issue(16'h0000, 16'h0000);

        // Start pulses while busy and during DONE are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_bcd = 16'h1111;
        bus.b_bcd = 16'h2222;
        ref_add(16'h1111, 16'h2222, e.sum, e.cout, e.err);
        e.cyc = cyc + 1 + DIGITS;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_bcd = 16'h5555;
        bus.b_bcd = 16'h5555;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (DIGITS - 2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        issue(16'h0123, 16'h0456);

        // Reset mid-operation aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_bcd = 16'h4567;
        bus.b_bcd = 16'h4444;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        repeat (DIGITS + 3) @(negedge clk);
        issue(16'h0005, 16'h0005);

        // Invalid digit, then a valid add
        issue(16'h00A0, 16'h0000);
        issue(16'h0012, 16'h0034);
        issue(16'hFFFF, 16'hFFFF);

        // Randomized adds with random idle gaps
        for (int k = 0; k < 40; k++) begin
            issue(rand_operand(1'b1), rand_operand(1'b1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        drain();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_serial_add_ctrl
